// File: rtl/mdu.sv
// Multiply/divide unit holding the architectural HI/LO registers. Results are
// computed when an operation is accepted and committed to HI/LO after a fixed
// multi-cycle latency, mimicking the timing of an iterative unit.
module mdu (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Req,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MUL_LAST = 4'd4;  // 5-cycle multiply
  localparam logic [3:0] DIV_LAST = 4'd9;  // 10-cycle divide

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        busy_next;
  logic [31:0] temp_hi, temp_hi_next;
  logic [31:0] temp_lo, temp_lo_next;
  logic [31:0] hi_next, lo_next;

  // Datapath: products and quotients for the operands presented this cycle.
  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg, b_zero;
  logic [31:0] a_mag, b_mag, b_safe;
  logic [31:0] q_mag, r_mag;
  logic [31:0] divu_q, divu_r;
  logic [31:0] div_q, div_r;
  logic        is_mul, is_div, accept;
  logic [31:0] res_hi, res_lo;

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide is done on magnitudes so the most-negative dividend over -1
  // wraps cleanly to 0x80000000 with a zero remainder.
  assign a_neg  = A[31];
  assign b_neg  = B[31];
  assign b_zero = (B == 32'd0);
  assign a_mag  = a_neg ? (32'd0 - A) : A;
  assign b_mag  = b_neg ? (32'd0 - B) : B;
  assign b_safe = b_zero ? 32'd1 : B;

  assign q_mag  = a_mag / (b_zero ? 32'd1 : b_mag);
  assign r_mag  = a_mag % (b_zero ? 32'd1 : b_mag);
  assign div_q  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign div_r  = a_neg ? (32'd0 - r_mag) : r_mag;
  assign divu_q = A / b_safe;
  assign divu_r = A % b_safe;

  assign is_mul = (MDOp == OP_MULT) || (MDOp == OP_MULTU);
  assign is_div = (MDOp == OP_DIV)  || (MDOp == OP_DIVU);
  assign accept = (state == IDLE) && Start && !Req && (is_mul || is_div);

  // Divide by zero re-commits the current HI/LO, leaving them unchanged.
  always_comb begin
    res_hi = HI;
    res_lo = LO;
    case (MDOp)
      OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      OP_DIV:   if (!b_zero) begin res_hi = div_r;  res_lo = div_q;  end
      OP_DIVU:  if (!b_zero) begin res_hi = divu_r; res_lo = divu_q; end
      default:  begin res_hi = HI; res_lo = LO; end
    endcase
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    busy_next    = Busy;
    temp_hi_next = temp_hi;
    temp_lo_next = temp_lo;
    hi_next      = HI;
    lo_next      = LO;
    case (state)
      IDLE: begin
        if (accept) begin
          temp_hi_next = res_hi;
          temp_lo_next = res_lo;
          cnt_next     = is_mul ? MUL_LAST : DIV_LAST;
          busy_next    = 1'b1;
          state_next   = RUN;
        end else if (!Req && MDOp == OP_MTHI) begin
          hi_next = A;
        end else if (!Req && MDOp == OP_MTLO) begin
          lo_next = A;
        end
      end
      RUN: begin
        // Req and new requests are ignored here; the operation always commits.
        if (cnt == 4'd0) begin
          hi_next    = temp_hi;
          lo_next    = temp_lo;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      Busy    <= 1'b0;
      temp_hi <= 32'd0;
      temp_lo <= 32'd0;
      HI      <= 32'd0;
      LO      <= 32'd0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      Busy    <= busy_next;
      temp_hi <= temp_hi_next;
      temp_lo <= temp_lo_next;
      HI      <= hi_next;
      LO      <= lo_next;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed corner cases plus randomized
// operations compared against a plain-arithmetic model of HI/LO.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A, B;
  logic        Req;
  logic        Busy;
  logic [31:0] HI, LO;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mdu dut (
    .clk   (clk),
    .reset (reset),
    .Start (Start),
    .MDOp  (MDOp),
    .A     (A),
    .B     (B),
    .Req   (Req),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic r);
    Start = s;
    MDOp  = op;
    A     = a;
    B     = b;
    Req   = r;
  endtask

  function automatic int op_cycles(input logic [2:0] op);
    return (op == 3'd1 || op == 3'd2) ? 5 : 10;
  endfunction

  // Reference: 64-bit integer arithmetic straight from the operation definitions.
  task automatic model_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] nh, output logic [31:0] nl);
    longint      sa, sb, q, r;
    logic [63:0] p;
    nh = m_hi;
    nl = m_lo;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: begin p = sa * sb; nh = p[63:32]; nl = p[31:0]; end
      3'd2: begin p = {32'd0, a} * {32'd0, b}; nh = p[63:32]; nl = p[31:0]; end
      3'd3: if (b != 0) begin q = sa / sb; r = sa % sb; nl = q[31:0]; nh = r[31:0]; end
      3'd4: if (b != 0) begin nl = a / b; nh = a % b; end
      default: ;
    endcase
  endtask

  // Issue one mult/div and check Busy plus frozen HI/LO every cycle, then the
  // commit. Optionally inject an extra request on cycle inj_cyc of the run.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int inj_cyc, input logic [2:0] inj_op, input logic inj_start,
                        input logic inj_req, input string tag);
    logic [31:0] nh, nl, old_hi, old_lo;
    int n;
    model_result(op, a, b, nh, nl);
    exp_q.push_back(nh);
    exp_q.push_back(nl);
    n = op_cycles(op);
    old_hi = m_hi;
    old_lo = m_lo;
    @(negedge clk);
    drive(1'b1, op, a, b, 1'b0);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      check({tag, " busy"}, {31'd0, Busy}, 32'd1);
      check({tag, " hi_hold"}, HI, old_hi);
      check({tag, " lo_hold"}, LO, old_lo);
      if (i == inj_cyc) drive(inj_start, inj_op, $urandom, $urandom, inj_req);
      else drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    end
    @(negedge clk);
    check({tag, " busy_done"}, {31'd0, Busy}, 32'd0);
    check({tag, " hi"}, HI, exp_q.pop_front());
    check({tag, " lo"}, LO, exp_q.pop_front());
    m_hi = nh;
    m_lo = nl;
  endtask

  // Single-cycle request that should never raise Busy.
  task automatic quick_op(input logic s, input logic [2:0] op, input logic [31:0] a,
                          input logic r, input string tag);
    @(negedge clk);
    drive(s, op, a, 32'd0, r);
    if (!r && op == 3'd5) m_hi = a;
    if (!r && op == 3'd6) m_lo = a;
    @(negedge clk);
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    check({tag, " busy"}, {31'd0, Busy}, 32'd0);
    check({tag, " hi"}, HI, m_hi);
    check({tag, " lo"}, LO, m_lo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] ra, rb;

    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    reset = 1'b1;
    #1;
    check("reset busy", {31'd0, Busy}, 32'd0);
    check("reset hi", HI, 32'd0);
    check("reset lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op(3'd1, 32'hFFFFFFFE, 32'd3, 0, 3'd0, 1'b0, 1'b0, "mult");
    check("mult hi const", HI, 32'hFFFFFFFF);
    check("mult lo const", LO, 32'hFFFFFFFA);
    run_op(3'd2, 32'hFFFFFFFE, 32'd3, 0, 3'd0, 1'b0, 1'b0, "multu");
    check("multu hi const", HI, 32'h00000002);
    check("multu lo const", LO, 32'hFFFFFFFA);
    run_op(3'd3, 32'hFFFFFFF9, 32'd2, 0, 3'd0, 1'b0, 1'b0, "div");
    check("div hi const", HI, 32'hFFFFFFFF);
    check("div lo const", LO, 32'hFFFFFFFD);
    run_op(3'd4, 32'd7, 32'd0, 0, 3'd0, 1'b0, 1'b0, "divu_by0");
    check("divu_by0 hi const", HI, 32'hFFFFFFFF);
    check("divu_by0 lo const", LO, 32'hFFFFFFFD);
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 0, 3'd0, 1'b0, 1'b0, "div_ovf");
    check("div_ovf hi const", HI, 32'h00000000);
    check("div_ovf lo const", LO, 32'h80000000);
    run_op(3'd3, $urandom, 32'd0, 0, 3'd0, 1'b0, 1'b0, "div_by0");

    quick_op(1'b0, 3'd6, 32'h12345678, 1'b0, "mtlo");
    check("mtlo const", LO, 32'h12345678);
    quick_op(1'b0, 3'd5, 32'hDEADBEEF, 1'b1, "mthi_req");
    quick_op(1'b1, 3'd1, 32'h00001234, 1'b1, "mult_req");
    quick_op(1'b1, 3'd0, 32'h00000055, 1'b0, "start_none");
    quick_op(1'b1, 3'd7, 32'h00000077, 1'b0, "start_op7");
    quick_op(1'b1, 3'd5, 32'hCAFEF00D, 1'b0, "start_mthi");

    run_op(3'd1, 32'h00012345, 32'hFFFF0001, 2, 3'd5, 1'b0, 1'b0, "mult_mthi");
    run_op(3'd3, 32'd1000, 32'hFFFFFFF9, 3, 3'd0, 1'b0, 1'b1, "div_req");
    run_op(3'd2, $urandom, $urandom, 1, 3'd1, 1'b1, 1'b0, "multu_start");

    // Reset mid-run discards the pending divide.
    @(negedge clk);
    drive(1'b1, 3'd3, 32'd100, 32'd7, 1'b0);
    @(negedge clk);
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst busy", {31'd0, Busy}, 32'd0);
    check("midrst hi", HI, 32'd0);
    check("midrst lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    run_op(3'd1, 32'd6, 32'd7, 0, 3'd0, 1'b0, 1'b0, "post_rst_mult");
    check("post_rst lo const", LO, 32'd42);

    for (int k = 0; k < 30; k++) begin
      op = 3'($urandom_range(1, 6));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
      if ($urandom_range(0, 5) == 0) rb = 32'hFFFFFFFF;
      if (op <= 3'd4) run_op(op, ra, rb, 0, 3'd0, 1'b0, 1'b0, "rand_op");
      else quick_op(1'b0, op, ra, 1'b0, "rand_move");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
